pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline-stage register. It is the next generation of the fixed-field inter-stage registers (ID/EX, EX/MEM, MEM/WB).
- It carries a generic payload split into two parts: control bits that are cleared to a bubble when invalid, and data bits that are simply held.
- It uses a valid/ready handshake in place of a global stall, with an optional 2-entry skid buffer so in_ready can be registered.
- It adds a synchronous flush and a stall-cycle performance counter. All inter-stage registers in the 5-stage core will be instanced from this block.

Parameters:
- DATA_W, 64: payload data bits (register values, immediates, load-half data); never cleared by flush.
- CTRL_W, 8: payload control bits (opcode, rd, mem_write, WriteReg, …); forced to 0 whenever the output is not valid.
- SKID, 1: 0 selects a single-entry stage with combinational in_ready; 1 selects a 2-entry skid stage with registered in_ready.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-low.
- flush, input, 1: synchronous flush; discards all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept this cycle.
- in_data, input, DATA_W: upstream data payload.
- in_ctrl, input, CTRL_W: upstream control payload.
- out_valid, output, 1: downstream entry valid.
- out_ready, input, 1: downstream accepts this cycle.
- out_data, output, DATA_W: head-entry data.
- out_ctrl, output, CTRL_W: head-entry control; 0 when out_valid=0.
- occupancy, output, 2: number of valid entries held (0..2).
- stall_cnt, output, CNT_W: saturating count of back-pressured cycles.

Behaviour:
- Reset (rst=0 at an edge):
  - All entries become invalid; the main and skid data/ctrl registers go to 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready is forced to 0 while rst=0. Reset overrides flush and all handshakes.
- Transfers:
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - in_valid may drop without acceptance. in_data and in_ctrl are sampled only on a push.
- Latency: 1 cycle. An entry pushed at edge N is visible on out_* after edge N.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- SKID=0 (single entry, "main"):
  - in_ready = !main_valid | out_ready (combinational; only legal when downstream ready is registered).
  - Push with pop in the same cycle replaces main.
  - Pop with no push empties main.
  - Push into an empty stage fills main.
  - occupancy ≤ 1.
- SKID=1 (main + skid; output always taken from main):
  - in_ready = !skid_valid (a register, no combinational path from out_ready).
  - Empty: a push fills main.
  - Main valid, no pop, push: the entry goes to skid; in_ready=0 from the next cycle.
  - Main valid, pop, push, skid empty: the new entry goes to main.
  - Skid valid (full), pop: skid moves to main; skid empties; in_ready=1 next cycle. No push is possible this cycle because in_ready=0.
  - Main valid, pop, no push, skid empty: the stage goes empty.
- Flush (rst=1, flush=1):
  - After the edge all entries are invalid, out_valid=0, out_ctrl=0, occupancy=0.
  - A push offered in the same cycle is discarded; its in_ready value is still driven normally.
  - Data registers keep their old contents.
  - Flush asserted for several cycles keeps the stage empty.
- Bubble rule: out_ctrl = main_ctrl & {CTRL_W{main_valid}}. out_data is not masked.
- occupancy = main_valid + skid_valid, registered.
- stall_cnt:
  - Increments by 1 at each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W−1; does not wrap.
  - Cleared only by rst. Flush does not clear it.

Test Plan:
- Reset then stream (SKID=1, out_ready=1):
  - Hold rst=0 for 2 cycles: all outputs 0 and in_ready=0.
  - Release rst and push ctrl 0x11/0x12/0x13 on consecutive cycles: out_ctrl shows 0x11, 0x12, 0x13 one cycle later, back-to-back; occupancy=1; stall_cnt=0.
- Back-pressure and skid (SKID=1):
  - Drop out_ready after 0x11 arrives, then push 0x12: occupancy=2, in_ready=0, and stall_cnt increments by 1 each cycle.
  - Raise out_ready: 0x11 pops, then 0x12, with no loss. in_ready returns to 1 one cycle after the first pop.
- Flush while full (SKID=1):
  - With 0xA1/0xA2 held, assert flush together with in_valid and ctrl 0xA3.
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0; 0xA3 never appears.
  - out_data still shows the previous main data.
- Single-entry mode (SKID=0):
  - With out_ready=0 and the stage full: in_ready=0.
  - Raise out_ready and push 0x5 in the same cycle: in_ready=1 in that cycle; 0x5 appears next cycle; occupancy stays 1.
- Saturation (CNT_W=4):
  - Hold out_valid=1 and out_ready=0 for 20 cycles: stall_cnt stops at 15.
  - Flush: stall_cnt stays at 15. rst=0: stall_cnt goes to 0.
- Reset mid-operation (SKID=1):
  - With occupancy=2 and out_ready=0, pull rst low for 1 cycle together with flush=1: all state goes to 0 and in_ready=0 during the reset cycle.
  - The next push after reset appears after 1 cycle.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: valid/ready handshake, optional 2-entry skid,
// synchronous flush, bubble-masked control payload and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              push, pop;

  // Skid mode keeps in_ready off the out_ready path; single-entry mode does not.
  assign in_ready = (SKID != 0) ? (rst & ~skid_vld_q)
                                : (rst & (~main_vld_q | out_ready));
  assign push = in_valid & in_ready;
  assign pop  = main_vld_q & out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (SKID != 0) begin
      if (skid_vld_q) begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_vld_d  = 1'b0;
        end
      end else if (main_vld_q) begin
        if (pop && push) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (pop) begin
          main_vld_d = 1'b0;
        end else if (push) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          skid_vld_d  = 1'b1;
        end
      end else if (push) begin
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
        main_vld_d  = 1'b1;
      end
    end else begin
      if (push) begin
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
        main_vld_d  = 1'b1;
      end else if (pop) begin
        main_vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_vld_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Flush drops entries but leaves payload registers untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
      end else begin
        main_vld_q  <= main_vld_d;
        skid_vld_q  <= skid_vld_d;
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
      end
    end
  end

  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_vld_q}};
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a skid instance and a single-entry instance,
// each with an expected-entry queue drained by an independent output monitor.
module tb_pipe_stage_elastic;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Skid instance signals
  logic          rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  // Single-entry instance signals
  logic          s_rst = 1'b0, s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [DW-1:0] s_in_data = '0;
  logic [CW-1:0] s_in_ctrl = '0;
  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [CW-1:0] s_out_ctrl;
  logic [1:0]    s_occupancy;
  logic [NW-1:0] s_stall_cnt;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_single (
    .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

  logic [CW+DW-1:0] q_skid[$];
  logic [CW+DW-1:0] q_single[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one offered entry on the skid instance; expect=1 queues it for the monitor.
  task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    if (expect_out) q_skid.push_back({c, d});
  endtask

  // Monitors: a handshake visible at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      if (q_skid.size() == 0) begin
        total++; bad++;
        $display("FAIL skid_unexpected_pop: got 0x%0h expected none", {out_ctrl, out_data});
      end else begin
        chk("skid_pop", {8'h0, out_ctrl, out_data}, {8'h0, q_skid.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (s_rst && !s_flush && s_out_valid && s_out_ready) begin
      if (q_single.size() == 0) begin
        total++; bad++;
        $display("FAIL single_unexpected_pop: got 0x%0h expected none", {s_out_ctrl, s_out_data});
      end else begin
        chk("single_pop", {8'h0, s_out_ctrl, s_out_data}, {8'h0, q_single.pop_front()});
      end
    end
  end

  initial begin
    // ---- reset then stream ----
    tick; tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl",  out_ctrl, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_occ",       occupancy, 0);
    chk("rst_stall",     stall_cnt, 0);
    chk("rst_in_ready",  in_ready, 0);
    rst = 1'b1;
    offer(8'h11, 16'h1011, 1);
    tick;
    chk("s1_ctrl", out_ctrl, 8'h11);
    chk("s1_in_ready", in_ready, 1);
    offer(8'h12, 16'h1012, 1);
    tick;
    chk("s2_ctrl", out_ctrl, 8'h12);
    chk("s2_occ", occupancy, 1);
    offer(8'h13, 16'h1013, 1);
    tick;
    chk("s3_ctrl", out_ctrl, 8'h13);
    chk("s3_occ", occupancy, 1);
    chk("s3_stall", stall_cnt, 0);
    in_valid = 1'b0;
    tick;
    chk("s4_empty_valid", out_valid, 0);
    chk("s4_empty_ctrl", out_ctrl, 0);

    // ---- back-pressure and skid ----
    offer(8'h11, 16'h2011, 1);
    tick;
    out_ready = 1'b0;
    offer(8'h12, 16'h2012, 1);
    tick;
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_stall1", stall_cnt, 1);
    chk("bp_head", out_ctrl, 8'h11);
    in_valid = 1'b0;
    tick;
    chk("bp_stall2", stall_cnt, 2);
    tick;
    chk("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    tick;
    chk("bp_head2", out_ctrl, 8'h12);
    chk("bp_occ1", occupancy, 1);
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_stall_hold", stall_cnt, 3);
    tick;
    chk("bp_drained", occupancy, 0);

    // ---- flush while full ----
    out_ready = 1'b0;
    offer(8'hA1, 16'h00A1, 0);
    tick;
    offer(8'hA2, 16'h00A2, 0);
    tick;
    chk("fl_full", occupancy, 2);
    chk("fl_stall4", stall_cnt, 4);
    flush = 1'b1;
    offer(8'hA3, 16'h00A3, 0);
    tick;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_data_kept", out_data, 16'h00A1);
    chk("fl_stall_kept", stall_cnt, 5);
    flush = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("fl_no_a3", out_valid, 0);
    flush = 1'b1;
    offer(8'hA4, 16'h00A4, 0);
    #1;
    chk("fl_in_ready_driven", in_ready, 1);
    tick;
    chk("fl_push_dropped", out_valid, 0);
    chk("fl_push_data_kept", out_data, 16'h00A1);
    flush = 1'b0;
    in_valid = 1'b0;

    // ---- stall counter saturation ----
    offer(8'hB1, 16'h00B1, 0);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    chk("sat_15", stall_cnt, 15);
    flush = 1'b1;
    tick;
    chk("sat_flush_kept", stall_cnt, 15);
    chk("sat_flush_occ", occupancy, 0);
    flush = 1'b0;

    // ---- reset mid-operation ----
    offer(8'hC1, 16'h00C1, 0);
    tick;
    offer(8'hC2, 16'h00C2, 0);
    tick;
    chk("mr_occ2", occupancy, 2);
    in_valid = 1'b0;
    rst = 1'b0;
    flush = 1'b1;
    #1;
    chk("mr_in_ready_low", in_ready, 0);
    tick;
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_stall", stall_cnt, 0);
    chk("mr_in_ready", in_ready, 0);
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    offer(8'hD1, 16'h00D1, 1);
    #1;
    chk("mr_ready_after", in_ready, 1);
    tick;
    chk("mr_d1", out_ctrl, 8'hD1);
    in_valid = 1'b0;
    tick;
    chk("mr_drained", occupancy, 0);

    // ---- single-entry mode ----
    s_rst = 1'b1;
    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    s_in_ctrl = 8'h04;
    s_in_data = 16'h0004;
    q_single.push_back({8'h04, 16'h0004});
    #1;
    chk("se_ready_empty", s_in_ready, 1);
    tick;
    chk("se_full_not_ready", s_in_ready, 0);
    s_in_valid = 1'b0;
    tick;
    chk("se_stall1", s_stall_cnt, 1);
    chk("se_occ1", s_occupancy, 1);
    s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    s_in_ctrl = 8'h05;
    s_in_data = 16'h0005;
    q_single.push_back({8'h05, 16'h0005});
    #1;
    chk("se_ready_passthru", s_in_ready, 1);
    tick;
    chk("se_ctrl5", s_out_ctrl, 8'h05);
    chk("se_occ_stays1", s_occupancy, 1);
    chk("se_stall_hold", s_stall_cnt, 1);
    s_in_valid = 1'b0;
    tick;
    chk("se_empty", s_occupancy, 0);
    chk("se_bubble", s_out_ctrl, 0);

    tick;
    chk("skid_queue_drained", q_skid.size(), 0);
    chk("single_queue_drained", q_single.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
